// File: rtl/fft_pkg.sv
// Shared FFT definitions: transform size, sample format and the bit-reverse
// index helper used by the reorder buffer.
package fft_pkg;

    localparam int FFT_N     = 32;
    localparam int FFT_LOG2N = $clog2(FFT_N);
    localparam int FFT_DW    = 14;

    // Signed Q6.8 complex sample as produced by the last butterfly stage.
    typedef struct packed {
        logic signed [FFT_DW-1:0] re;
        logic signed [FFT_DW-1:0] im;
    } sample_t;

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL,
        BANK_DRAINING
    } bank_state_t;

    function automatic logic [FFT_LOG2N-1:0] bitrev(input logic [FFT_LOG2N-1:0] a);
        logic [FFT_LOG2N-1:0] r;
        for (int i = 0; i < FFT_LOG2N; i++) begin
            r[i] = a[FFT_LOG2N-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One ping-pong half of the FFT output reorder buffer: an N-entry sample store
// with a synchronous write port, combinational read port and fill/drain tracking.
module fft_reorder_bank
    import fft_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [FFT_LOG2N-1:0] waddr,
    input  sample_t              wdata,
    input  logic [FFT_LOG2N-1:0] raddr,
    output sample_t              rdata,
    input  logic                 set_full,
    input  logic                 rd_xfer,
    input  logic                 clr_full,
    output logic                 full
);

    sample_t     mem [FFT_N];
    bank_state_t state, state_nxt;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BANK_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        if (clr_full) begin
            // The final read releases the bank even if another event coincides.
            state_nxt = BANK_EMPTY;
        end else begin
            case (state)
                BANK_EMPTY: begin
                    if (set_full)  state_nxt = BANK_FULL;
                    else if (we)   state_nxt = BANK_FILLING;
                end
                BANK_FILLING: begin
                    if (set_full)  state_nxt = BANK_FULL;
                end
                BANK_FULL: begin
                    if (rd_xfer)   state_nxt = BANK_DRAINING;
                end
                BANK_DRAINING: begin
                    state_nxt = BANK_DRAINING;
                end
                default: state_nxt = BANK_EMPTY;
            endcase
        end
    end

    assign full = (state == BANK_FULL) || (state == BANK_DRAINING);

    // NOTE: the store is built from flops and cleared on reset so the outputs
    // read as zero after reset and no stale frame can leak out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FFT_N; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fft_reorder_out.sv
// Ping-pong output reorder buffer for the 32-point SDF FFT: accepts bit-reversed
// frames and emits natural-order bins. FFT_REORDER_OVF_EN adds the err_ovf flag.
module fft_reorder_out
    import fft_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [FFT_DW-1:0]    in_r,
    input  logic [FFT_DW-1:0]    in_i,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [FFT_DW-1:0]    out_r,
    output logic [FFT_DW-1:0]    out_i,
    output logic [FFT_LOG2N-1:0] out_idx,
`ifdef FFT_REORDER_OVF_EN
    output logic                 err_ovf,
`endif
    output logic                 out_last
);

    localparam logic [FFT_LOG2N-1:0] LAST_IDX = FFT_LOG2N'(FFT_N - 1);

    logic                 wr_bank, rd_bank;
    logic [FFT_LOG2N-1:0] wr_cnt, rd_cnt;
    logic [1:0]           full;
    logic [1:0]           bank_we, bank_set, bank_xfer, bank_clr;
    sample_t              bank_rd [2];
    sample_t              in_sample;
    sample_t              rd_sample;
    logic                 accept, wr_wrap, xfer;

    assign in_sample = '{re: in_r, im: in_i};

    assign in_ready = !full[wr_bank];
    assign accept   = in_valid && in_ready;
    assign wr_wrap  = accept && (wr_cnt == LAST_IDX);

    assign out_valid = full[rd_bank];
    assign out_last  = out_valid && (rd_cnt == LAST_IDX);
    assign xfer      = out_valid && out_ready;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign bank_we[b]   = accept && (wr_bank == 1'(b));
        assign bank_set[b]  = wr_wrap && (wr_bank == 1'(b));
        assign bank_xfer[b] = xfer && (rd_bank == 1'(b));
        assign bank_clr[b]  = xfer && out_last && (rd_bank == 1'(b));

        fft_reorder_bank u_bank (
            .clk      (clk),
            .rst      (rst),
            .we       (bank_we[b]),
            .waddr    (bitrev(wr_cnt)),
            .wdata    (in_sample),
            .raddr    (rd_cnt),
            .rdata    (bank_rd[b]),
            .set_full (bank_set[b]),
            .rd_xfer  (bank_xfer[b]),
            .clr_full (bank_clr[b]),
            .full     (full[b])
        );
    end

    // Outputs come only from registered state through this mux.
    assign rd_sample = bank_rd[rd_bank];
    assign out_r     = rd_sample.re;
    assign out_i     = rd_sample.im;
    assign out_idx   = rd_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank <= 1'b0;
            wr_cnt  <= '0;
        end else if (accept) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (wr_wrap) begin
                wr_bank <= !wr_bank;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_bank <= 1'b0;
            rd_cnt  <= '0;
        end else if (xfer) begin
            rd_cnt <= rd_cnt + 1'b1;
            if (out_last) begin
                rd_bank <= !rd_bank;
            end
        end
    end

`ifdef FFT_REORDER_OVF_EN
    // The SDF pipeline cannot stall, so any refused sample is lost data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_ovf <= 1'b0;
        end else if (in_valid && !in_ready) begin
            err_ovf <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/fft_reorder_out.md
# fft_reorder_out

Output reorder buffer for the 32-point radix-2 SDF FFT pipeline. Sits after the last butterfly stage and consumes its bit-reversed output stream. Emits each frame in natural frequency order (X[0]..X[31]) through a valid/ready handshake. Ping-pong storage lets one frame be written while the previous frame drains, so throughput is one sample per cycle with no bubbles.

## Interface
- N, 32: FFT size in samples; power of two; LOG2N = $clog2(N).
- DW, 14: sample width per component; signed, 6 integer / 8 fractional bits, matching the butterfly output.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_r/in_i hold a sample from the last butterfly stage.
- in_ready  out  1  buffer can accept a sample this cycle.
- in_r, in_i  in  DW  signed sample, bit-reversed frame order.
- out_valid  out  1  out_r/out_i/out_idx valid.
- out_ready  in  1  downstream accepts the sample this cycle.
- out_r, out_i  out  DW  signed sample, natural order.
- out_idx  out  LOG2N  frequency bin index of the current output.
- out_last  out  1  high with bin N-1.
- err_ovf  out  1  sticky overflow flag. Present only with FFT_REORDER_OVF_EN.

## Operation
- Storage: two banks, each N x (2·DW) flops, reset to 0. Per-bank full flag.
- Write side:
  - wr_bank (1 bit) and wr_cnt (LOG2N bits).
  - An accept is in_valid && in_ready.
  - An accept stores the sample at address bitrev(wr_cnt) in wr_bank, then increments wr_cnt.
  - When wr_cnt == N-1 on an accept: set full[wr_bank], toggle wr_bank, and wr_cnt wraps to 0.
- in_ready = !full[wr_bank].
- Read side:
  - rd_bank and rd_cnt.
  - out_valid = full[rd_bank].
  - out_r/out_i = bank[rd_bank][rd_cnt].
  - out_idx = rd_cnt.
  - out_last = out_valid && rd_cnt == N-1.
- A transfer is out_valid && out_ready.
  - A transfer increments rd_cnt.
  - On the out_last transfer: clear full[rd_bank], toggle rd_bank, rd_cnt wraps to 0.
- Per-bank states: EMPTY → FILLING (first write) → FULL (N-th write) → DRAINING (first read) → EMPTY (last read).
  - A bank cannot be written while FULL or DRAINING.
- Data passes unmodified. No rounding, scaling or sign change; -8192 and 8191 pass bit-exact.
- Simultaneous set/clear of the same bank's full flag cannot occur, because in_ready is derived from the registered flags. The implementation must still give clear priority.
- Both banks full: in_ready = 0, and outputs keep draining.
- Reset mid-frame:
  - All counters and bank selects go to 0 and full flags clear.
  - Partial frames are discarded.
  - The first accept after reset is sample 0 of a new frame.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_r = out_i = 0, out_idx = 0, out_last = 0, err_ovf = 0.
- Output data/valid are driven from registered state (flags, counters, banks) through a read mux only. There is no combinational path from in_* or out_ready to any output.
- Latency: last input accepted at edge k → out_valid = 1 with bin 0 in the cycle after edge k.
- Sustained rate: 1 sample/cycle when out_ready stays high.
  - Frame f+1 writes while frame f drains.
  - in_ready never drops.
- out_r/out_i/out_idx are held stable while out_valid && !out_ready.

## Configuration
- FFT_REORDER_OVF_EN defined:
  - err_ovf port exists.
  - err_ovf sets on any cycle with in_valid && !in_ready.
  - err_ovf clears only on rst.
  - The upstream SDF pipeline cannot stall, so this flags lost data.
- Not defined: no err_ovf port and no detection logic. Behaviour is otherwise identical.

## Structure
- Shared package fft_pkg holds:
  - FFT_N, FFT_LOG2N, FFT_DW.
  - typedef sample_t (signed [FFT_DW-1:0] real/imag pair).
  - function bitrev (LOG2N-bit reverse).
- One sub-module: fft_reorder_bank. It holds one N-entry storage array plus its full flag, with a write port, a combinational read port, and set/clear inputs. It is instantiated twice.

## Test plan
- Single frame: inputs with in_r = arrival index k (0..31), in_i = -k, out_ready = 1.
  - Expected: out_r = bitrev(n) at bin n, e.g. bin1 = 16, bin2 = 8, bin31 = 31.
  - out_valid rises 1 cycle after the 32nd accept; out_last on bin 31.
- Back-to-back: 4 frames with continuous in_valid and out_ready = 1.
  - in_ready stays 1 throughout.
  - 128 outputs arrive with no gaps, in correct order per frame.
- Backpressure: out_ready = 0 while streaming.
  - in_ready drops after exactly 64 accepts.
  - Raising out_ready for 32 transfers re-raises in_ready the cycle after out_last.
  - Outputs are held stable while stalled.
- Extremes: frame of -8192 / 8191 alternating in real/imag → reproduced bit-exact.
- Reset mid-frame: assert rst after 10 accepts.
  - All outputs return to reset values.
  - A fresh 32-sample frame afterwards reorders correctly with no stale data.
- FFT_REORDER_OVF_EN: with both banks full, drive in_valid for 1 cycle.
  - err_ovf = 1 and stays 1 until rst.
  - Without the macro, this scenario compiles with no err_ovf port.
